// File: rtl/ifns_gbx_pkg.sv
// ifns_gbx_pkg: shared widths and buffer sizing for the IFNS transmit gearbox
package ifns_gbx_pkg;
  localparam int IFNS_DATA_W = 22;
  localparam int IFNS_GBX_IN_W = 16;
  function automatic int gbx_buf_w(input int in_w, input int out_w);
    return in_w + out_w - 1;
  endfunction
endpackage

// File: rtl/ifns_gbx_outreg.sv
// ifns_gbx_outreg: stage-B symbol register feeding the encoder datain
// IFNS_GBX_HOLD_EN: keep data/pad after a consume instead of clearing them
module ifns_gbx_outreg
  import ifns_gbx_pkg::*;
#(
  parameter int W = IFNS_DATA_W
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_pad,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_pad
);
  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_pad;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pad   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pad   <= i_pad;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
`ifdef IFNS_GBX_HOLD_EN
      r_data  <= r_data;
      r_pad   <= r_pad;
`else
      r_data  <= '0;
      r_pad   <= 1'b0;
`endif
    end
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pad   = r_pad;
endmodule

// File: rtl/ifns_tx_gearbox.sv
// ifns_tx_gearbox: packs IN_W-bit words LSB-first into OUT_W-bit encoder symbols
// Optional IFNS_GBX_HOLD_EN holds the output bus when a symbol is consumed
module ifns_tx_gearbox
  import ifns_gbx_pkg::*;
#(
  parameter int IN_W = IFNS_GBX_IN_W,
  parameter int OUT_W = IFNS_DATA_W,
  localparam int BUF_W = gbx_buf_w(IN_W, OUT_W),
  localparam int CNT_W = $clog2(BUF_W + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_pad,
  output logic [CNT_W-1:0] level
);
  logic [BUF_W-1:0] r_buf, w_buf_nxt, w_in_ext;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_popped;
  logic             r_flush_pend, w_push, w_b_free, w_full_pop, w_pad_pop;
  logic [OUT_W-1:0] w_pad_mask;

  assign in_ready   = (r_cnt <= CNT_W'(BUF_W - IN_W)) && !r_flush_pend;
  assign w_push     = in_valid && in_ready;
  assign w_b_free   = !out_valid || out_ready;
  assign w_full_pop = w_b_free && (r_cnt >= CNT_W'(OUT_W));
  assign w_pad_pop  = w_b_free && r_flush_pend && (r_cnt != '0) && (r_cnt < CNT_W'(OUT_W));
  assign w_popped   = w_full_pop ? CNT_W'(OUT_W) : w_pad_pop ? r_cnt : '0;
  assign w_in_ext   = BUF_W'(in_data);
  assign w_buf_nxt  = (r_buf >> w_popped) | (w_push ? w_in_ext << (r_cnt - w_popped) : '0);
  assign w_cnt_nxt  = r_cnt - w_popped + (w_push ? CNT_W'(IN_W) : '0);
  assign w_pad_mask = ~({OUT_W{1'b1}} << r_cnt);
  assign level      = r_cnt;

  // flush_pend also clears when full pops alone empty the buffer
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      r_buf        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_buf        <= w_buf_nxt;
      r_cnt        <= w_cnt_nxt;
      r_flush_pend <= r_flush_pend ? !(w_pad_pop || w_cnt_nxt == '0)
                                   : flush && (r_cnt != '0 || w_push);
    end

  ifns_gbx_outreg #(.W(OUT_W)) u_outreg (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_load  (w_full_pop || w_pad_pop),
    .i_data  (w_pad_pop ? r_buf[OUT_W-1:0] & w_pad_mask : r_buf[OUT_W-1:0]),
    .i_pad   (w_pad_pop),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_pad   (out_pad)
  );
endmodule
